// File: rtl/mio_bus_responder_pkg.sv
// Shared region codes, FSM/request-kind encodings and defaults for the MIO bus responder.
// No logic, no latency, no backpressure.
package mio_bus_responder_pkg;

   localparam int RAM_WAIT_DEF = 2;

   localparam logic [3:0] REG_RAM  = 4'h0;
   localparam logic [3:0] REG_GPIO = 4'hE;
   localparam logic [3:0] REG_CNT  = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      KIND_RD  = 2'd0,
      KIND_WR  = 2'd1,
      KIND_ERR = 2'd2
   } kind_t;

endpackage

// File: rtl/mio_timer.sv
// Free-running wrapping up-counter; a load replaces the increment in the same cycle.
// Latency: load visible the cycle after ld_en; never stalls.
module mio_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld_en,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt_d = ld_en ? ld_val : cnt_q + W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO slave: decodes one request at a time to RAM/GPIO/counter and answers with a one-cycle mio_ready.
// Latency: peripherals and protocol errors N+1, RAM N+1+RAM_WAIT; the next request is accepted in the IDLE cycle after RESP.
module mio_bus_responder
   import mio_bus_responder_pkg::*;
#(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = RAM_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic              cpu_mio,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              mio_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       gpio_in,
   output logic [31:0]       gpio_out
);

   state_t            state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       gpio_q;
   logic [RAM_AW-1:0] ram_wa_q;
   logic [31:0]       wdata_q;
   kind_t             kind_q;
   logic [3:0]        region_q;

   logic              req;
   logic              accept;
   kind_t             kind_in;
   kind_t             sel_kind;
   logic [3:0]        sel_region;
   logic              wr_en;
   logic              gpio_ld;
   logic              cnt_ld;
   logic [31:0]       cnt;
   logic              unused_addr;

   assign req         = cpu_mio & (mem_r | mem_w);
   assign accept      = (state_q == IDLE) && req;
   assign kind_in     = (mem_r & mem_w) ? KIND_ERR : (mem_w ? KIND_WR : KIND_RD);
   assign unused_addr = ^{addr[27:RAM_AW+2], addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Only clean RAM requests pay wait states; a rd+wr error completes like a peripheral.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (addr[31:28] == REG_RAM && kind_in != KIND_ERR) begin
                  state_d = WAIT;
                  wait_d  = 4'(RAM_WAIT - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (wait_q == 4'd0) state_d = RESP;
            else                wait_d  = wait_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mio_ready = 1'b0;
      wr_en     = 1'b0;
      if (state_q == RESP) begin
         mio_ready = 1'b1;
         wr_en     = (kind_q == KIND_WR);
      end
      ram_we   = wr_en && (region_q == REG_RAM);
      gpio_ld  = wr_en && (region_q == REG_GPIO);
      cnt_ld   = wr_en && (region_q == REG_CNT);
      // Present the incoming address while idle so a synchronous RAM has data by the end of the first WAIT cycle.
      ram_addr = (state_q == IDLE) ? addr[RAM_AW+1:2] : ram_wa_q;
   end

   always_comb begin
      rdata_d    = rdata_q;
      sel_kind   = (state_q == IDLE) ? kind_in : kind_q;
      sel_region = (state_q == IDLE) ? addr[31:28] : region_q;
      if (state_d == RESP && state_q != RESP) begin
         if (sel_kind == KIND_RD) begin
            case (sel_region)
               REG_RAM:  rdata_d = ram_dout;
               REG_GPIO: rdata_d = {16'h0, gpio_in};
               REG_CNT:  rdata_d = cnt;
               default:  rdata_d = '0;
            endcase
         end else if (sel_kind == KIND_ERR) begin
            rdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q   <= '0;
         rdata_q  <= '0;
         gpio_q   <= '0;
         ram_wa_q <= '0;
         wdata_q  <= '0;
         kind_q   <= KIND_RD;
         region_q <= '0;
      end else begin
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         if (gpio_ld) gpio_q <= wdata_q;
         if (accept) begin
            ram_wa_q <= addr[RAM_AW+1:2];
            wdata_q  <= wdata;
            kind_q   <= kind_in;
            region_q <= addr[31:28];
         end
      end
   end

   mio_timer #(.W(32)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .ld_en  (cnt_ld),
      .ld_val (wdata_q),
      .cnt    (cnt)
   );

   assign rdata    = rdata_q;
   assign ram_din  = wdata_q;
   // The GPIO write is visible on the pins already during RESP.
   assign gpio_out = gpio_ld ? wdata_q : gpio_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a synchronous RAM model.
module tb_mio_bus_responder;

   localparam int RAM_AW   = 10;
   localparam int RAM_WAIT = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_r, mem_w, cpu_mio;
   logic [31:0]       addr, wdata;
   logic [31:0]       rdata;
   logic              mio_ready;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic              ram_we;
   logic [31:0]       ram_dout;
   logic [15:0]       gpio_in;
   logic [31:0]       gpio_out;

   mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_r     (mem_r),
      .mem_w     (mem_w),
      .cpu_mio   (cpu_mio),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .mio_ready (mio_ready),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [0:(1<<RAM_AW)-1];
   initial begin
      for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = '0;
      ram_dout = '0;
   end
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // One CPU access held until ready; lat = ready cycle minus accept cycle, -1 on timeout.
   task automatic do_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output int wes,
                         output logic [RAM_AW-1:0] wa, output logic [31:0] wd,
                         output logic [31:0] gpo);
      int  s;
      bit  done;
      @(negedge clk);
      cpu_mio = 1'b1;
      mem_r   = r;
      mem_w   = w;
      addr    = a;
      wdata   = d;
      s       = cyc;
      lat     = -1;
      rd      = '0;
      wes     = 0;
      wa      = '0;
      wd      = '0;
      gpo     = '0;
      done    = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (ram_we) begin
            wes++;
            wa = ram_addr;
            wd = ram_din;
         end
         if (mio_ready) begin
            lat  = cyc - s;
            rd   = rdata;
            gpo  = gpio_out;
            done = 1'b1;
         end
      end
      mem_r   = 1'b0;
      mem_w   = 1'b0;
      cpu_mio = 1'b0;
   endtask

   typedef struct {
      logic              r;
      logic              w;
      logic [31:0]       a;
      logic [31:0]       d;
      logic [15:0]       gi;
      int                lat;
      logic [31:0]       rd;
      int                wes;
      logic [RAM_AW-1:0] wa;
      logic [31:0]       gpo;
   } vec_t;

   vec_t v[12];

   int                lat, wes, nwe, nrdy, prev;
   logic [31:0]       rd, wd, gpo;
   logic [RAM_AW-1:0] wa;
   logic [31:0]       ba[4];
   logic [31:0]       bexp[4];
   int                blat[4];
   bit                got;

   initial begin
      //         r     w     addr          wdata         gpio_in  lat rdata         we wa      gpio_out
      v[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 3, 32'h0000_0000, 1, 10'd4, 32'h0000_0000};
      v[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 3, 32'hDEAD_BEEF, 0, 10'd0, 32'h0000_0000};
      v[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 16'h0000, 3, 32'hDEAD_BEEF, 1, 10'd5, 32'h0000_0000};
      v[3]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 16'h0000, 3, 32'hCAFE_F00D, 0, 10'd0, 32'h0000_0000};
      v[4]  = '{1'b1, 1'b0, 32'hE000_0000, 32'h0000_0000, 16'hA5A5, 1, 32'h0000_A5A5, 0, 10'd0, 32'h0000_0000};
      v[5]  = '{1'b0, 1'b1, 32'hE000_0000, 32'h1234_5678, 16'hA5A5, 1, 32'h0000_A5A5, 0, 10'd0, 32'h1234_5678};
      v[6]  = '{1'b1, 1'b0, 32'hE000_0004, 32'h0000_0000, 16'h5A3C, 1, 32'h0000_5A3C, 0, 10'd0, 32'h1234_5678};
      v[7]  = '{1'b1, 1'b0, 32'h5000_0000, 32'h0000_0000, 16'h5A3C, 1, 32'h0000_0000, 0, 10'd0, 32'h1234_5678};
      v[8]  = '{1'b0, 1'b1, 32'h5000_0000, 32'hFFFF_FFFF, 16'h5A3C, 1, 32'h0000_0000, 0, 10'd0, 32'h1234_5678};
      v[9]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 16'h5A3C, 1, 32'h0000_0000, 0, 10'd0, 32'h1234_5678};
      v[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h5A3C, 3, 32'hDEAD_BEEF, 0, 10'd0, 32'h1234_5678};
      v[11] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0000_0000, 16'h5A3C, 3, 32'hDEAD_BEEF, 0, 10'd0, 32'h1234_5678};

      ba   = '{32'h0000_0010, 32'hE000_0000, 32'h0000_0014, 32'h5000_0000};
      bexp = '{32'hDEAD_BEEF, 32'h0000_1234, 32'hCAFE_F00D, 32'h0000_0000};
      blat = '{3, 1, 3, 1};

      reset   = 1'b1;
      mem_r   = 1'b0;
      mem_w   = 1'b0;
      cpu_mio = 1'b0;
      addr    = '0;
      wdata   = '0;
      gpio_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'b0, mio_ready}, 32'd0);
      chk("reset_we", {31'b0, ram_we}, 32'd0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_gpio_out", gpio_out, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         gpio_in = v[i].gi;
         do_txn(v[i].r, v[i].w, v[i].a, v[i].d, lat, rd, wes, wa, wd, gpo);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("vec%0d_rdata", i), rd, v[i].rd);
         chk($sformatf("vec%0d_we_pulses", i), 32'(wes), 32'(v[i].wes));
         if (v[i].wes > 0) begin
            chk($sformatf("vec%0d_ram_addr", i), 32'(wa), 32'(v[i].wa));
            chk($sformatf("vec%0d_ram_din", i), wd, v[i].d);
         end
         chk($sformatf("vec%0d_gpio_out", i), gpo, v[i].gpo);
      end

      // Counter load then reads: FFFFFFFE loaded, read accepted 3 cycles after the write's RESP wraps to 0.
      do_txn(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, lat, rd, wes, wa, wd, gpo);
      chk("cnt_wr_latency", 32'(lat), 32'd1);
      repeat (2) @(negedge clk);
      do_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, rd, wes, wa, wd, gpo);
      chk("cnt_rd1_latency", 32'(lat), 32'd1);
      chk("cnt_rd1_wrap", rd, 32'h0000_0000);
      do_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, wes, wa, wd, gpo);
      chk("cnt_rd2_value", rd, 32'h0000_0002);

      // Request without bus ownership must never complete.
      @(negedge clk);
      cpu_mio = 1'b0;
      mem_r   = 1'b1;
      addr    = 32'hE000_0000;
      nrdy    = 0;
      repeat (10) begin
         @(negedge clk);
         if (mio_ready) nrdy++;
      end
      mem_r = 1'b0;
      chk("no_mio_ready", 32'(nrdy), 32'd0);

      // Reset while a RAM write sits in WAIT.
      @(negedge clk);
      cpu_mio = 1'b1;
      mem_w   = 1'b1;
      addr    = 32'h0000_0020;
      wdata   = 32'h0000_0077;
      @(negedge clk);
      reset   = 1'b1;
      mem_w   = 1'b0;
      cpu_mio = 1'b0;
      nwe     = 0;
      nrdy    = 0;
      #1;
      chk("rst_mid_gpio_out", gpio_out, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      repeat (3) begin
         @(negedge clk);
         if (ram_we) nwe++;
         if (mio_ready) nrdy++;
      end
      reset = 1'b0;
      do_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, wes, wa, wd, gpo);
      nwe += wes;
      chk("rst_mid_cnt_latency", 32'(lat), 32'd1);
      chk("rst_mid_cnt_value", rd, 32'h0000_0001);
      do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, rd, wes, wa, wd, gpo);
      nwe += wes;
      chk("rst_mid_ram_latency", 32'(lat), 32'd3);
      chk("rst_mid_ram_unwritten", rd, 32'h0);
      chk("rst_mid_we_pulses", 32'(nwe), 32'd0);
      chk("rst_mid_ready_pulses", 32'(nrdy), 32'd0);

      // Back-to-back reads, request held until ready and retargeted on the ready cycle.
      @(negedge clk);
      gpio_in = 16'h1234;
      cpu_mio = 1'b1;
      mem_r   = 1'b1;
      mem_w   = 1'b0;
      addr    = ba[0];
      prev    = cyc - 1;
      nrdy    = 0;
      for (int i = 0; i < 4; i++) begin
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mio_ready) begin
               got = 1'b1;
               nrdy++;
               chk($sformatf("b2b%0d_spacing", i), 32'(cyc - prev), 32'(blat[i] + 1));
               chk($sformatf("b2b%0d_rdata", i), rdata, bexp[i]);
               prev = cyc;
               if (i < 3) begin
                  addr = ba[i+1];
               end else begin
                  mem_r   = 1'b0;
                  cpu_mio = 1'b0;
               end
            end
         end
         chk($sformatf("b2b%0d_completed", i), {31'b0, got}, 32'd1);
      end
      mem_r   = 1'b0;
      cpu_mio = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (mio_ready) nrdy++;
      end
      chk("b2b_ready_pulses", 32'(nrdy), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO responder at the slave end of the CPU MIO bus driven by the multicycle controller (MemRead, MemWrite, CPU_MIO, MIO_ready).
- Accepts one request at a time and decodes the address to RAM, GPIO or the timer counter.
- Inserts RAM wait states, then returns read data with a single-cycle ready pulse.
- Sits between the CPU datapath and the RAM/peripheral blocks.

Parameters:
- RAM_AW, 10, RAM word-address width; ram_addr = latched addr[RAM_AW+1:2].
- RAM_WAIT, 2, wait cycles for RAM accesses; legal range 1..15. Minimum 1 covers synchronous RAM read latency.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_r  in  1  CPU read request (MemRead)
- mem_w  in  1  CPU write request (MemWrite)
- cpu_mio  in  1  CPU owns the bus; requests are ignored while 0
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data (registered)
- mio_ready  out  1  completion pulse (MIO_ready)
- ram_addr  out  RAM_AW  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write strobe
- ram_dout  in  32  RAM read data; valid 1 cycle after ram_addr
- gpio_in  in  16  switch inputs
- gpio_out  out  32  LED/output register

Behaviour:
- Reset: asynchronous, active-high; clock clk.
- Reset values: state IDLE; rdata, gpio_out, counter, wait counter and latches all 0; mio_ready=0, ram_we=0.
- Address map, decoded on addr[31:28]:
  - 0x0: RAM.
  - 0xE: GPIO. Read returns {16'h0, gpio_in}; write loads gpio_out.
  - 0xF: counter. Read returns the count; write loads it.
  - Any other region is unmapped: read returns 0, write is ignored, completion still occurs.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - A request is cpu_mio & (mem_r | mem_w).
  - On a request, latch addr, wdata, kind and region.
  - RAM region: go to WAIT with the wait counter = RAM_WAIT-1. All other regions: go to RESP.
  - No request: stay in IDLE.
- WAIT:
  - ram_addr is driven from the latched address.
  - Decrement the counter each cycle; go to RESP when it is 0.
  - Resulting RAM latency: mio_ready is high in cycle N+1+RAM_WAIT, where N is the IDLE accept cycle.
- RESP: lasts exactly one cycle.
  - mio_ready=1.
  - Writes take effect in this cycle: ram_we=1 for RAM writes (ram_din = latched wdata); gpio_out or counter load for peripheral writes.
  - rdata is loaded on the transition into RESP and holds until the next read completes.
  - Next state is always IDLE.
- Peripheral latency: mio_ready in cycle N+1.
- Back-to-back requests: the earliest next accept is the IDLE cycle after RESP. The CPU state change and request removal happen on the ready edge, so a request is never double-accepted.
- mem_r and mem_w both set: protocol error. No write occurs, rdata=0, and the request completes with the peripheral latency (N+1).
- Request inputs changing after acceptance are ignored; only latched values are used.
- Counter:
  - Free-running 32-bit up counter, wrapping 0xFFFFFFFF→0.
  - A write load in RESP overrides the increment for that cycle.
  - A read returns the value as of the transition into RESP.
- Reset asserted mid-transaction (WAIT or RESP): immediate return to IDLE with no write performed and mio_ready=0.

Decomposition:
- Shared package holds:
  - Region codes REG_RAM=4'h0, REG_GPIO=4'hE, REG_CNT=4'hF.
  - State encoding IDLE/WAIT/RESP.
  - The RAM_WAIT default.
- One natural sub-module: mio_timer, the 32-bit counter with load enable and load value.

Test Plan:
- RAM write then read: write 0x00000010 with data 0xDEADBEEF, then read 0x00000010, RAM_WAIT=2. Required: mio_ready high 3 cycles after each accept; exactly one ram_we pulse, with ram_addr=4; rdata=0xDEADBEEF.
- GPIO: gpio_in=0xA5A5, read 0xE0000000 → rdata=0x0000A5A5, ready 1 cycle after accept. Write 0x12345678 → gpio_out=0x12345678 from the RESP cycle onward.
- Counter: write 0xFFFFFFFE to 0xF0000004, then read back 2 cycles later. Required: read value reflects wrap through 0 (for example 0x00000000 or 0x00000001 per exact timing); verify by cycle count.
- Unmapped and error cases:
  - Read 0x50000000 → rdata=0, ready at N+1.
  - mem_r=mem_w=1 to RAM address → no ram_we, rdata=0, ready at N+1.
  - cpu_mio=0 with mem_r=1 → no ready, ever.
- Reset mid-transaction: assert reset during WAIT of a RAM write → ram_we never pulses, mio_ready=0, gpio_out and counter are 0. The following request completes normally.
- Back-to-back: CPU-like driver issues 4 sequential reads (IF-style, request held until ready). Required: each completes with a single ready pulse, no duplicated accepts, and the IDLE gap between transactions is exactly 1 cycle.
